// File: rtl/detect_event_counter_pkg.sv
// Shared constants for detect_event_counter: BCD digit width and active-low
// seven-segment patterns (bit6 = g ... bit0 = a) for the DE2 displays.
package detect_event_counter_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A   = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B   = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C   = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D   = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E   = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F   = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // Pattern shown for a digit value that is not legal on a BCD display.
    localparam logic [SEG_W-1:0] SEG_BLANK = SEG_OFF;

    // Full hexadecimal lookup; callers decide whether 10-15 are legal.
    function automatic logic [SEG_W-1:0] seg7_hex(input logic [DIGIT_W-1:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/detect_event_counter_seg7_decode.sv
// seg7_decode: 4-bit value to active-low seven-segment pattern.
// HEX_EN = 1 shows 0-F; HEX_EN = 0 treats 10-15 as illegal and blanks them.
module seg7_decode
    import detect_event_counter_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [SEG_W-1:0]   seg_o
);

    // Purely combinational lookup with blanking of non-BCD values in BCD mode.
    always_comb begin
        seg_o = seg7_hex(digit_i);
        if (!HEX_EN && (digit_i > 4'd9)) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/detect_event_counter.sv
// detect_event_counter: turns each 0->1 transition of the detector output z
// into a one-cycle event_pulse, counts events in a two-digit BCD counter and
// drives two active-low DE2 seven-segment displays.
// Optional build macro RUN_LENGTH_EN adds run-length tracking of z with a
// peak_run output shown on HEX2/HEX3.
//
// Output timing: event_pulse is a one-cycle valid strobe with no ready/back-
// pressure; count_ones/count_tens/overflow/HEX0/HEX1 already show the updated
// count in the same cycle event_pulse is high.
module detect_event_counter
    import detect_event_counter_pkg::*;
#(
    parameter int SATURATE = 0,
    parameter int Z_ACTIVE = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               z,
    input  logic               Clear,
    output logic               event_pulse,
    output logic [DIGIT_W-1:0] count_ones,
    output logic [DIGIT_W-1:0] count_tens,
    output logic               overflow,
    output logic [SEG_W-1:0]   HEX0,
    output logic [SEG_W-1:0]   HEX1
`ifdef RUN_LENGTH_EN
    ,
    output logic [7:0]         peak_run,
    output logic [SEG_W-1:0]   HEX2,
    output logic [SEG_W-1:0]   HEX3
`endif
);

    logic               zi;
    logic               z_s_q;
    logic               z_prev_q;
    logic               rise;
    logic               event_pulse_q;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic               ovf_q, ovf_d;

    // Normalise polarity so the rest of the logic always looks for a 0->1 edge.
    assign zi   = (Z_ACTIVE != 0) ? z : ~z;
    assign rise = z_s_q & ~z_prev_q;

    // BCD next-count: Clear beats increment; at 99 flag overflow and wrap or hold.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        ovf_d  = ovf_q;
        if (Clear) begin
            ones_d = '0;
            tens_d = '0;
            ovf_d  = 1'b0;
        end else if (rise) begin
            if ((ones_q == 4'd9) && (tens_q == 4'd9)) begin
                ovf_d = 1'b1;
                if (SATURATE == 0) begin
                    ones_d = '0;
                    tens_d = '0;
                end
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Input sync, edge history, event strobe and count registers; Reset wins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            z_s_q         <= 1'b0;
            z_prev_q      <= 1'b0;
            event_pulse_q <= 1'b0;
            ones_q        <= '0;
            tens_q        <= '0;
            ovf_q         <= 1'b0;
        end else begin
            z_s_q         <= zi;
            z_prev_q      <= z_s_q;
            event_pulse_q <= rise;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            ovf_q         <= ovf_d;
        end
    end

    assign event_pulse = event_pulse_q;
    assign count_ones  = ones_q;
    assign count_tens  = tens_q;
    assign overflow    = ovf_q;

    seg7_decode #(.HEX_EN(1'b0)) u_hex0 (
        .digit_i (ones_q),
        .seg_o   (HEX0)
    );

    seg7_decode #(.HEX_EN(1'b0)) u_hex1 (
        .digit_i (tens_q),
        .seg_o   (HEX1)
    );

`ifdef RUN_LENGTH_EN
    logic [7:0] run_len_q, run_len_d;
    logic [7:0] peak_q, peak_d;

    // Run length of z_s high (saturating at 255) and the largest run seen.
    always_comb begin
        run_len_d = '0;
        if (z_s_q) begin
            run_len_d = (run_len_q == 8'hFF) ? run_len_q : run_len_q + 8'd1;
        end
        peak_d = peak_q;
        if (Clear) begin
            peak_d = '0;
        end else if (run_len_q > peak_q) begin
            peak_d = run_len_q;
        end
    end

    // Run-length and peak registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            run_len_q <= '0;
            peak_q    <= '0;
        end else begin
            run_len_q <= run_len_d;
            peak_q    <= peak_d;
        end
    end

    assign peak_run = peak_q;

    seg7_decode #(.HEX_EN(1'b1)) u_hex2 (
        .digit_i (peak_q[3:0]),
        .seg_o   (HEX2)
    );

    seg7_decode #(.HEX_EN(1'b1)) u_hex3 (
        .digit_i (peak_q[7:4]),
        .seg_o   (HEX3)
    );
`endif

endmodule

// File: tb/tb_detect_event_counter.sv
// Bench for detect_event_counter: a wrapping instance and a saturating
// instance share the same stimulus; expected results are queued by the
// drivers and consumed by a monitor whenever event_pulse appears.
module tb_detect_event_counter;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic z     = 1'b0;
    logic Clear = 1'b0;
    int   cyc   = 0;

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic       ep_w, ep_s;
    logic [3:0] ones_w, tens_w, ones_s, tens_s;
    logic       ov_w_o, ov_s_o;
    logic [6:0] hex0_w, hex1_w, hex0_s, hex1_s;
`ifdef RUN_LENGTH_EN
    logic [7:0] peak_w, peak_s;
    logic [6:0] hex2_w, hex3_w, hex2_s, hex3_s;
`endif

    detect_event_counter #(.SATURATE(0), .Z_ACTIVE(1)) dut_w (
        .Clock       (Clock),
        .Reset       (Reset),
        .z           (z),
        .Clear       (Clear),
        .event_pulse (ep_w),
        .count_ones  (ones_w),
        .count_tens  (tens_w),
        .overflow    (ov_w_o),
        .HEX0        (hex0_w),
        .HEX1        (hex1_w)
`ifdef RUN_LENGTH_EN
        ,
        .peak_run    (peak_w),
        .HEX2        (hex2_w),
        .HEX3        (hex3_w)
`endif
    );

    detect_event_counter #(.SATURATE(1), .Z_ACTIVE(1)) dut_s (
        .Clock       (Clock),
        .Reset       (Reset),
        .z           (z),
        .Clear       (Clear),
        .event_pulse (ep_s),
        .count_ones  (ones_s),
        .count_tens  (tens_s),
        .overflow    (ov_s_o),
        .HEX0        (hex0_s),
        .HEX1        (hex1_s)
`ifdef RUN_LENGTH_EN
        ,
        .peak_run    (peak_s),
        .HEX2        (hex2_s),
        .HEX3        (hex3_s)
`endif
    );

    // Hand-written DE2 active-low patterns for digits 0-9.
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // ---------------- scoreboard ----------------
    // Packed entry: {due_cycle[15:0], tens_w, ones_w, ov_w, tens_s, ones_s, ov_s}
    localparam int EXP_W = 34;
    logic [EXP_W-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: plain integer counts for both instances.
    int   n_w  = 0;
    int   n_s  = 0;
    logic mo_w = 1'b0;
    logic mo_s = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cyc %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        n_w = 0; n_s = 0; mo_w = 1'b0; mo_s = 1'b0;
    endtask

    task automatic model_event(input bit clr);
        if (clr) begin
            model_reset();
        end else begin
            if (n_w == 99) begin n_w = 0; mo_w = 1'b1; end
            else n_w++;
            if (n_s == 99) mo_s = 1'b1;
            else n_s++;
        end
    endtask

    task automatic push_exp(input int due);
        logic [15:0] d;
        d = 16'(due);
        exp_q.push_back({d, 4'(n_w / 10), 4'(n_w % 10), mo_w,
                            4'(n_s / 10), 4'(n_s % 10), mo_s});
    endtask

    // Compare the steady (no-pulse) state of both instances with the model.
    task automatic check_state(input string tag);
        check({tag, "_pulse_w"}, ep_w, 0);
        check({tag, "_pulse_s"}, ep_s, 0);
        check({tag, "_count_w"}, tens_w * 10 + ones_w, n_w);
        check({tag, "_count_s"}, tens_s * 10 + ones_s, n_s);
        check({tag, "_ovf_w"}, ov_w_o, mo_w);
        check({tag, "_ovf_s"}, ov_s_o, mo_s);
        check({tag, "_hex0_w"}, hex0_w, SEG_TAB[n_w % 10]);
        check({tag, "_hex1_w"}, hex1_w, SEG_TAB[n_w / 10]);
        check({tag, "_hex0_s"}, hex0_s, SEG_TAB[n_s % 10]);
        check({tag, "_hex1_s"}, hex1_s, SEG_TAB[n_s / 10]);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: z high for n_high rising edges, then low for
    // n_low edges (n_low >= 1). With clr set, Clear coincides with the rise.
    task automatic pulse_z(input int n_high, input int n_low, input bit clr);
        z = 1'b1;
        model_event(clr);
        push_exp(cyc + 2);
        for (int i = 0; i < n_high; i++) begin
            @(negedge Clock);
            Clear = clr && (i == 0);
        end
        z = 1'b0;
        for (int i = 0; i < n_low; i++) begin
            @(negedge Clock);
            Clear = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge Clock);
            if (ep_w || ep_s) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse at cyc %0d: actual w=%0b s=%0b required none",
                             cyc, ep_w, ep_s);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, int'(e[33:18]));
                    check("pulse_w", ep_w, 1);
                    check("pulse_s", ep_s, 1);
                    check("ev_tens_w", tens_w, e[17:14]);
                    check("ev_ones_w", ones_w, e[13:10]);
                    check("ev_ovf_w", ov_w_o, e[9]);
                    check("ev_tens_s", tens_s, e[8:5]);
                    check("ev_ones_s", ones_s, e[4:1]);
                    check("ev_ovf_s", ov_s_o, e[0]);
                    check("ev_hex0_w", hex0_w, SEG_TAB[e[13:10]]);
                    check("ev_hex1_w", hex1_w, SEG_TAB[e[17:14]]);
                    check("ev_hex0_s", hex0_s, SEG_TAB[e[4:1]]);
                    check("ev_hex1_s", hex1_s, SEG_TAB[e[8:5]]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset, then idle z: count 00, displays "0", no pulses.
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        check_state("reset");
        repeat (5) @(negedge Clock);
        check_state("idle");

        // Long z high: one event, count 01.
        pulse_z(6, 2, 1'b0);

        // Up to 09, then the BCD carry to 10.
        for (int i = 0; i < 8; i++) pulse_z(1, 1, 1'b0);
        pulse_z(1, 1, 1'b0);

        // Up to 42, then Clear together with the rise.
        for (int i = 0; i < 32; i++) pulse_z(1, 1, 1'b0);
        pulse_z(1, 1, 1'b1);
        repeat (2) @(negedge Clock);
        check_state("after_clear_rise");

        // 100 isolated pulses (1,0,1 spacing), then one more past the top.
        for (int i = 0; i < 100; i++) pulse_z(1, 1, 1'b0);
        pulse_z(1, 2, 1'b0);
        check_state("past_99");

        // Standalone Clear drops count and sticky overflow.
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        model_reset();
        check_state("clear");

        // A couple of events, then Reset right where a pulse would appear,
        // with z held high through the Reset release.
        pulse_z(1, 1, 1'b0);
        pulse_z(1, 1, 1'b0);
        z = 1'b1;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        model_reset();
        check_state("reset_mid");
        @(negedge Clock);
        Reset = 1'b0;
        model_event(1'b0);
        push_exp(cyc + 2);
        repeat (3) @(negedge Clock);
        z = 1'b0;
        repeat (3) @(negedge Clock);
        check_state("after_reset_hold");

`ifdef RUN_LENGTH_EN
        // Runs of 3 then 7 cycles: peak 7, shown as "07".
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        model_reset();
        pulse_z(3, 1, 1'b0);
        pulse_z(7, 4, 1'b0);
        check("peak_w", peak_w, 7);
        check("peak_s", peak_s, 7);
        check("hex2_w", hex2_w, 7'b1111000);
        check("hex3_w", hex3_w, 7'b1000000);
        check("hex2_s", hex2_s, 7'b1111000);
        check("hex3_s", hex3_s, 7'b1000000);
`endif

        // Drain: every queued event must have been observed.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clock);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detect_event_counter.md
Name: detect_event_counter

Overview:
- Downstream consumer of the 4-in-a-row sequence-detector output `z`.
- Converts each new detection (0→1 transition of `z`) into a one-cycle event pulse.
- Counts events in a 2-digit BCD counter (00–99) and drives two active-low DE2 seven-segment displays.
- Clocked from the same `Clock` as the detector FSM, so it sits directly on the detector's LEDR[17] net.

Parameters:
- SATURATE, 0, 0 = counter wraps 99→00 on the next event; 1 = counter holds at 99.
- Z_ACTIVE, 1, level of `z` treated as "detected"; 0 inverts the input before edge detection.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- z  input  1  detector output (level).
- Clear  input  1  synchronous counter clear, active-high.
- event_pulse  output  1  one-cycle pulse per detected rising edge of `z`.
- count_ones  output  4  BCD ones digit.
- count_tens  output  4  BCD tens digit.
- overflow  output  1  sticky; set on the first event arriving at count 99.
- HEX0  output  7  active-low segments for the ones digit; bit6 = g … bit0 = a.
- HEX1  output  7  active-low segments for the tens digit.

Behaviour:
- Reset has priority over everything. On Reset:
  - z_s = 0, z_prev = 0, event_pulse = 0, count = 00, overflow = 0.
  - HEX0 = HEX1 = 7'b1000000 (displays "0").
- Input stage:
  - zi = `z` XNOR Z_ACTIVE.
  - Edge k: z_s <= zi and z_prev <= z_s.
- Edge detect: rise = z_s & ~z_prev.
- Event pulse: event_pulse <= rise, registered.
  - One pulse per 0→1 transition of zi, regardless of how long `z` stays high.
- Latency:
  - `z` first sampled high at edge k → event_pulse high after edge k+1, for exactly one cycle.
  - The count updates on that same edge k+1.
- Back-to-back events: `z` pattern 1,0,1 at consecutive edges yields two pulses separated by one idle cycle.
- Counter priority: Reset > Clear > increment.
  - Clear coinciding with rise: count = 00 and overflow = 0; the event is not counted, but event_pulse still asserts.
- BCD increment:
  - ones 0–8 → ones+1.
  - ones 9 → ones = 0, tens+1.
  - At 99, SATURATE = 0: next is 00 and overflow is set.
  - At 99, SATURATE = 1: holds 99 and overflow is set.
  - Digits never take values 10–15.
- overflow is sticky. It is cleared only by Reset or Clear.
- Reset asserted mid-pulse: event_pulse drops on the reset edge, with no residual count.
- A `z` held high through Reset release counts as one event, because z_prev resets to 0.
- HEX outputs:
  - Combinational decode of the registered digits; they change in the same cycle as the count.
  - Digit values 0–9 use standard DE2 patterns.
  - Any illegal digit value decodes to all segments off (7'b1111111).

Optional Feature:
- RUN_LENGTH_EN
- Defined:
  - Adds 8-bit run_len, counting consecutive cycles with z_s = 1. It saturates at 255 and resets to 0 when z_s = 0.
  - Adds 8-bit peak_run output, holding the maximum run_len seen. It updates when run_len exceeds it and clears on Reset or Clear.
  - Adds HEX2/HEX3 ports, showing peak_run as hex digits.
- Undefined: none of these registers or ports exist, and the port list is exactly as above.

Decomposition:
- Shared package file holds:
  - BCD digit width (4).
  - Seven-segment patterns SEG_0…SEG_9, SEG_A…SEG_F and SEG_OFF, active-low, bit6 = g.
  - SEG_BLANK/illegal constant.
- One sub-module, `seg7_decode` (4-bit in → 7-bit active-low out, hex-capable). It is instantiated for HEX0/HEX1, and for HEX2/HEX3 under RUN_LENGTH_EN.
- The edge detector and BCD counter remain in the top module.

Test Plan:
- Reset, then `z` = 0 for 5 cycles → count 00, event_pulse never high, HEX0 = HEX1 = 7'b1000000.
- `z` high for 6 cycles, then low → exactly one event_pulse, 2 cycles after `z` rises; count 01; HEX0 = 7'b1111001.
- 100 isolated `z` pulses, SATURATE = 0 → count reaches 99 after pulse 99, then 00 with overflow = 1 after pulse 100. With SATURATE = 1 → holds 99, overflow = 1.
- Count 09, then one event → count_tens = 1, count_ones = 0 (BCD carry).
- Clear asserted in the same cycle as rise, at count 42 → event_pulse = 1, count 00, overflow 0.
- RUN_LENGTH_EN defined: `z` high 3 cycles, low, then high 7 cycles → peak_run = 7, HEX2 = SEG_7, HEX3 = SEG_0.
